// File: rtl/hbm_axi_pkg.sv
// Shared constants, command struct and FSM state types for the HBM AXI port master.
package hbm_axi_pkg;

    localparam int unsigned ADDR_W = 34;
    localparam int unsigned DATA_W = 256;
    localparam int unsigned ID_W   = 6;

    localparam logic [2:0] AXI_SIZE_32B = 3'b101;
    localparam logic [1:0] BURST_INCR   = 2'b01;
    localparam logic [1:0] RESP_OKAY    = 2'b00;

    localparam logic [ADDR_W-1:0] BEAT_ADDR_MASK = {{(ADDR_W-5){1'b1}}, 5'b0};

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_cmd_t;

    typedef enum logic [1:0] {WR_IDLE, WR_SEND, WR_FINISH} wr_state_t;
    typedef enum logic       {RD_IDLE, RD_SEND_AR}        rd_state_t;

    // Clears the byte offset inside a 32-byte beat; masking keeps every input bit in use.
    function automatic logic [ADDR_W-1:0] beat_align(input logic [ADDR_W-1:0] addr);
        return addr & BEAT_ADDR_MASK;
    endfunction

endpackage

// File: rtl/hbm_cmd_fifo.sv
// Synchronous power-of-two command FIFO with a registered full flag.
module hbm_cmd_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);

    localparam int unsigned  PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_next;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (do_push && !do_pop)
            count_next = count + CNT_ONE;
        else if (do_pop && !do_push)
            count_next = count - CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            count <= count_next;
            full  <= (count_next == FULL_CNT);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/hbm_axi_port_master.sv
// Single-beat AXI master for one HBM pseudo-channel: queues write/read commands
// and issues them as independent 32-byte AW+W and AR transactions.
module hbm_axi_port_master
    import hbm_axi_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH      = 16,
    parameter int unsigned MAX_OUTSTANDING = 16
) (
    input  logic                AXI_ACLK,
    input  logic                AXI_ARESET,
    input  logic                write_enable,
    input  logic [ADDR_W-1:0]   write_address,
    input  logic [DATA_W-1:0]   write_data,
    input  logic                read_enable,
    input  logic [ADDR_W-1:0]   read_address,
    output logic                wr_full,
    output logic                rd_full,
    output logic                rd_data_valid,
    output logic [DATA_W-1:0]   rd_data,
    output logic                wr_resp_err,
    output logic                rd_resp_err,
    output logic [ADDR_W-1:0]   AXI_AWADDR,
    output logic                AXI_AWVALID,
    input  logic                AXI_AWREADY,
    output logic [3:0]          AXI_AWLEN,
    output logic [2:0]          AXI_AWSIZE,
    output logic [1:0]          AXI_AWBURST,
    output logic [ID_W-1:0]     AXI_AWID,
    output logic [DATA_W-1:0]   AXI_WDATA,
    output logic [DATA_W/8-1:0] AXI_WSTRB,
    output logic                AXI_WLAST,
    output logic                AXI_WVALID,
    input  logic                AXI_WREADY,
    input  logic                AXI_BVALID,
    input  logic [1:0]          AXI_BRESP,
    output logic                AXI_BREADY,
    output logic [ADDR_W-1:0]   AXI_ARADDR,
    output logic                AXI_ARVALID,
    input  logic                AXI_ARREADY,
    output logic [3:0]          AXI_ARLEN,
    output logic [2:0]          AXI_ARSIZE,
    output logic [1:0]          AXI_ARBURST,
    output logic [ID_W-1:0]     AXI_ARID,
    input  logic [DATA_W-1:0]   AXI_RDATA,
    input  logic                AXI_RVALID,
    input  logic                AXI_RLAST,
    input  logic [1:0]          AXI_RRESP,
    output logic                AXI_RREADY
);

    localparam int unsigned      OUT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);
    localparam logic [OUT_W-1:0] OUT_ONE = 1;

    wr_state_t         wr_state;
    rd_state_t         rd_state;
    wr_cmd_t           wr_push_cmd;
    wr_cmd_t           wr_head;
    logic [ADDR_W-1:0] rd_head;
    logic              wr_empty;
    logic              rd_empty;
    logic              wr_pop;
    logic              rd_pop;
    logic              wr_aw_ok;
    logic              wr_w_ok;
    logic [OUT_W-1:0]  wr_outstanding;
    logic [OUT_W-1:0]  rd_outstanding;

    assign AXI_AWLEN   = '0;
    assign AXI_AWSIZE  = AXI_SIZE_32B;
    assign AXI_AWBURST = BURST_INCR;
    assign AXI_AWID    = '0;
    assign AXI_WSTRB   = '1;
    assign AXI_WLAST   = 1'b1;
    assign AXI_BREADY  = 1'b1;
    assign AXI_ARLEN   = '0;
    assign AXI_ARSIZE  = AXI_SIZE_32B;
    assign AXI_ARBURST = BURST_INCR;
    assign AXI_ARID    = '0;
    assign AXI_RREADY  = 1'b1;

    assign wr_push_cmd = {beat_align(write_address), write_data};

    hbm_cmd_fifo #(.WIDTH($bits(wr_cmd_t)), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
        .clk(AXI_ACLK), .rst(AXI_ARESET), .push(write_enable), .push_data(wr_push_cmd),
        .pop(wr_pop), .pop_data(wr_head), .empty(wr_empty), .full(wr_full)
    );

    hbm_cmd_fifo #(.WIDTH(ADDR_W), .DEPTH(FIFO_DEPTH)) u_rd_fifo (
        .clk(AXI_ACLK), .rst(AXI_ARESET), .push(read_enable), .push_data(beat_align(read_address)),
        .pop(rd_pop), .pop_data(rd_head), .empty(rd_empty), .full(rd_full)
    );

    // A channel is "ok" once its handshake has completed, this cycle or earlier.
    assign wr_aw_ok = !AXI_AWVALID || AXI_AWREADY;
    assign wr_w_ok  = !AXI_WVALID || AXI_WREADY;
    assign wr_pop   = (wr_state != WR_IDLE) && wr_aw_ok && wr_w_ok;
    assign rd_pop   = (rd_state == RD_SEND_AR) && AXI_ARREADY;

    always_ff @(posedge AXI_ACLK) begin
        if (AXI_ARESET) begin
            wr_state    <= WR_IDLE;
            AXI_AWVALID <= 1'b0;
            AXI_WVALID  <= 1'b0;
            AXI_AWADDR  <= '0;
            AXI_WDATA   <= '0;
        end else begin
            case (wr_state)
                WR_IDLE: begin
                    if (!wr_empty && (wr_outstanding < OUT_MAX)) begin
                        AXI_AWADDR  <= wr_head.addr;
                        AXI_WDATA   <= wr_head.data;
                        AXI_AWVALID <= 1'b1;
                        AXI_WVALID  <= 1'b1;
                        wr_state    <= WR_SEND;
                    end
                end
                default: begin
                    if (AXI_AWREADY)
                        AXI_AWVALID <= 1'b0;
                    if (AXI_WREADY)
                        AXI_WVALID <= 1'b0;
                    if (wr_pop)
                        wr_state <= WR_IDLE;
                    else if (wr_aw_ok || wr_w_ok)
                        wr_state <= WR_FINISH;
                end
            endcase
        end
    end

    always_ff @(posedge AXI_ACLK) begin
        if (AXI_ARESET) begin
            rd_state    <= RD_IDLE;
            AXI_ARVALID <= 1'b0;
            AXI_ARADDR  <= '0;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (!rd_empty && (rd_outstanding < OUT_MAX)) begin
                        AXI_ARADDR  <= rd_head;
                        AXI_ARVALID <= 1'b1;
                        rd_state    <= RD_SEND_AR;
                    end
                end
                default: begin
                    if (AXI_ARREADY) begin
                        AXI_ARVALID <= 1'b0;
                        rd_state    <= RD_IDLE;
                    end
                end
            endcase
        end
    end

    // Responses that outlive a reset must not wrap the counters below zero.
    always_ff @(posedge AXI_ACLK) begin
        if (AXI_ARESET) begin
            wr_outstanding <= '0;
            rd_outstanding <= '0;
        end else begin
            case ({AXI_AWVALID && AXI_AWREADY, AXI_BVALID})
                2'b10:   wr_outstanding <= wr_outstanding + OUT_ONE;
                2'b01:   if (wr_outstanding != '0) wr_outstanding <= wr_outstanding - OUT_ONE;
                default: wr_outstanding <= wr_outstanding;
            endcase
            case ({AXI_ARVALID && AXI_ARREADY, AXI_RVALID && AXI_RLAST})
                2'b10:   rd_outstanding <= rd_outstanding + OUT_ONE;
                2'b01:   if (rd_outstanding != '0) rd_outstanding <= rd_outstanding - OUT_ONE;
                default: rd_outstanding <= rd_outstanding;
            endcase
        end
    end

    always_ff @(posedge AXI_ACLK) begin
        if (AXI_ARESET) begin
            rd_data_valid <= 1'b0;
            rd_data       <= '0;
            wr_resp_err   <= 1'b0;
            rd_resp_err   <= 1'b0;
        end else begin
            rd_data_valid <= AXI_RVALID;
            rd_data       <= AXI_RDATA;
            if (AXI_BVALID && (AXI_BRESP != RESP_OKAY))
                wr_resp_err <= 1'b1;
            if (AXI_RVALID && (AXI_RRESP != RESP_OKAY))
                rd_resp_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hbm_axi_port_master.sv
// Scoreboard bench for hbm_axi_port_master: expected AW/W/AR/read beats are queued
// when stimulus is driven and compared when the DUT presents them.
module tb_hbm_axi_port_master;
    import hbm_axi_pkg::*;

    logic          clk = 1'b0;
    logic          AXI_ARESET;
    logic          write_enable, read_enable;
    logic [33:0]   write_address, read_address;
    logic [255:0]  write_data;
    logic          wr_full, rd_full, rd_data_valid, wr_resp_err, rd_resp_err;
    logic [255:0]  rd_data;
    logic [33:0]   AXI_AWADDR, AXI_ARADDR;
    logic          AXI_AWVALID, AXI_AWREADY, AXI_WLAST, AXI_WVALID, AXI_WREADY;
    logic [3:0]    AXI_AWLEN, AXI_ARLEN;
    logic [2:0]    AXI_AWSIZE, AXI_ARSIZE;
    logic [1:0]    AXI_AWBURST, AXI_ARBURST, AXI_BRESP, AXI_RRESP;
    logic [5:0]    AXI_AWID, AXI_ARID;
    logic [255:0]  AXI_WDATA, AXI_RDATA;
    logic [31:0]   AXI_WSTRB;
    logic          AXI_BVALID, AXI_BREADY, AXI_ARVALID, AXI_ARREADY;
    logic          AXI_RVALID, AXI_RLAST, AXI_RREADY;

    int n_checks = 0;
    int n_fail   = 0;

    logic [33:0]  exp_aw_q[$];
    logic [255:0] exp_w_q[$];
    logic [33:0]  exp_ar_q[$];
    logic [255:0] exp_rd_q[$];
    logic [33:0]  mon_a;
    logic [255:0] mon_d;

    always #5 clk = ~clk;

    hbm_axi_port_master #(.FIFO_DEPTH(16), .MAX_OUTSTANDING(16)) dut (
        .AXI_ACLK(clk), .AXI_ARESET(AXI_ARESET),
        .write_enable(write_enable), .write_address(write_address), .write_data(write_data),
        .read_enable(read_enable), .read_address(read_address),
        .wr_full(wr_full), .rd_full(rd_full), .rd_data_valid(rd_data_valid), .rd_data(rd_data),
        .wr_resp_err(wr_resp_err), .rd_resp_err(rd_resp_err),
        .AXI_AWADDR(AXI_AWADDR), .AXI_AWVALID(AXI_AWVALID), .AXI_AWREADY(AXI_AWREADY),
        .AXI_AWLEN(AXI_AWLEN), .AXI_AWSIZE(AXI_AWSIZE), .AXI_AWBURST(AXI_AWBURST), .AXI_AWID(AXI_AWID),
        .AXI_WDATA(AXI_WDATA), .AXI_WSTRB(AXI_WSTRB), .AXI_WLAST(AXI_WLAST),
        .AXI_WVALID(AXI_WVALID), .AXI_WREADY(AXI_WREADY),
        .AXI_BVALID(AXI_BVALID), .AXI_BRESP(AXI_BRESP), .AXI_BREADY(AXI_BREADY),
        .AXI_ARADDR(AXI_ARADDR), .AXI_ARVALID(AXI_ARVALID), .AXI_ARREADY(AXI_ARREADY),
        .AXI_ARLEN(AXI_ARLEN), .AXI_ARSIZE(AXI_ARSIZE), .AXI_ARBURST(AXI_ARBURST), .AXI_ARID(AXI_ARID),
        .AXI_RDATA(AXI_RDATA), .AXI_RVALID(AXI_RVALID), .AXI_RLAST(AXI_RLAST),
        .AXI_RRESP(AXI_RRESP), .AXI_RREADY(AXI_RREADY)
    );

    // Handshakes are sampled mid-cycle; inputs only change just after posedge.
    always @(negedge clk) begin
        if (!AXI_ARESET) begin
            if (AXI_AWVALID && AXI_AWREADY) begin
                n_checks++;
                if (exp_aw_q.size() == 0) begin
                    n_fail++; $display("FAIL aw_unexpected: got AWADDR %h, required no AW", AXI_AWADDR);
                end else begin
                    mon_a = exp_aw_q.pop_front();
                    if (AXI_AWADDR !== mon_a) begin
                        n_fail++; $display("FAIL aw_addr: got %h, required %h", AXI_AWADDR, mon_a);
                    end
                end
            end
            if (AXI_WVALID && AXI_WREADY) begin
                n_checks++;
                if (exp_w_q.size() == 0) begin
                    n_fail++; $display("FAIL w_unexpected: got WDATA %h, required no W", AXI_WDATA);
                end else begin
                    mon_d = exp_w_q.pop_front();
                    if (AXI_WDATA !== mon_d) begin
                        n_fail++; $display("FAIL w_data: got %h, required %h", AXI_WDATA, mon_d);
                    end
                end
            end
            if (AXI_ARVALID && AXI_ARREADY) begin
                n_checks++;
                if (exp_ar_q.size() == 0) begin
                    n_fail++; $display("FAIL ar_unexpected: got ARADDR %h, required no AR", AXI_ARADDR);
                end else begin
                    mon_a = exp_ar_q.pop_front();
                    if (AXI_ARADDR !== mon_a) begin
                        n_fail++; $display("FAIL ar_addr: got %h, required %h", AXI_ARADDR, mon_a);
                    end
                end
            end
            if (rd_data_valid) begin
                n_checks++;
                if (exp_rd_q.size() == 0) begin
                    n_fail++; $display("FAIL rd_unexpected: got rd_data %h, required no beat", rd_data);
                end else begin
                    mon_d = exp_rd_q.pop_front();
                    if (rd_data !== mon_d) begin
                        n_fail++; $display("FAIL rd_data: got %h, required %h", rd_data, mon_d);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_write(input logic [33:0] a, input logic [255:0] d, input bit accept);
        write_enable = 1'b1; write_address = a; write_data = d;
        if (accept) begin
            exp_aw_q.push_back(a & ~34'h1F);
            exp_w_q.push_back(d);
        end
        tick(1);
        write_enable = 1'b0;
    endtask

    task automatic push_read(input logic [33:0] a);
        read_enable = 1'b1; read_address = a;
        exp_ar_q.push_back(a & ~34'h1F);
        tick(1);
        read_enable = 1'b0;
    endtask

    task automatic send_b(input int n, input logic [1:0] resp);
        AXI_BVALID = 1'b1; AXI_BRESP = resp;
        tick(n);
        AXI_BVALID = 1'b0; AXI_BRESP = 2'b00;
    endtask

    task automatic wait_drain(input string name, input int max_cycles, output int cycles);
        cycles = 0;
        while ((exp_aw_q.size() + exp_w_q.size() + exp_ar_q.size()) != 0 && cycles < max_cycles) begin
            tick(1);
            cycles++;
        end
        n_checks++;
        if ((exp_aw_q.size() + exp_w_q.size() + exp_ar_q.size()) != 0) begin
            n_fail++;
            $display("FAIL %s: %0d transfers pending after %0d cycles, required 0", name,
                     exp_aw_q.size() + exp_w_q.size() + exp_ar_q.size(), cycles);
        end
    endtask

    task automatic test_reset();
        AXI_ARESET = 1'b1;
        tick(2);
        n_checks++;
        if ({AXI_AWVALID, AXI_WVALID, AXI_ARVALID, wr_full, rd_full, rd_data_valid, wr_resp_err, rd_resp_err} !== 8'h00) begin
            n_fail++; $display("FAIL reset_flags: got %b, required 00000000",
                {AXI_AWVALID, AXI_WVALID, AXI_ARVALID, wr_full, rd_full, rd_data_valid, wr_resp_err, rd_resp_err});
        end
        n_checks++;
        if ({AXI_BREADY, AXI_RREADY, AXI_WLAST} !== 3'b111) begin
            n_fail++; $display("FAIL ready_last: got %b, required 111", {AXI_BREADY, AXI_RREADY, AXI_WLAST});
        end
        n_checks++;
        if ({AXI_AWLEN, AXI_AWSIZE, AXI_AWBURST, AXI_AWID} !== {4'd0, 3'b101, 2'b01, 6'd0}) begin
            n_fail++; $display("FAIL aw_attrs: got %h, required %h",
                {AXI_AWLEN, AXI_AWSIZE, AXI_AWBURST, AXI_AWID}, {4'd0, 3'b101, 2'b01, 6'd0});
        end
        n_checks++;
        if ({AXI_ARLEN, AXI_ARSIZE, AXI_ARBURST, AXI_ARID} !== {4'd0, 3'b101, 2'b01, 6'd0}) begin
            n_fail++; $display("FAIL ar_attrs: got %h, required %h",
                {AXI_ARLEN, AXI_ARSIZE, AXI_ARBURST, AXI_ARID}, {4'd0, 3'b101, 2'b01, 6'd0});
        end
        n_checks++;
        if (AXI_WSTRB !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL wstrb: got %h, required ffffffff", AXI_WSTRB);
        end
        AXI_ARESET = 1'b0;
        tick(1);
    endtask

    task automatic test_single_write();
        AXI_AWREADY = 1'b1; AXI_WREADY = 1'b1;
        push_write(34'h0_0000_0020, 256'h4920, 1'b1);
        tick(1);
        n_checks++;
        if ({AXI_AWVALID, AXI_WVALID} !== 2'b11 || AXI_AWADDR !== 34'h20) begin
            n_fail++; $display("FAIL single_issue: got valids %b addr %h, required 11 addr 20",
                {AXI_AWVALID, AXI_WVALID}, AXI_AWADDR);
        end
        tick(1);
        n_checks++;
        if (AXI_AWVALID !== 1'b0 || dut.wr_outstanding !== 5'd1) begin
            n_fail++; $display("FAIL single_accept: got awvalid %b outstanding %0d, required 0 and 1",
                AXI_AWVALID, dut.wr_outstanding);
        end
        send_b(1, 2'b00);
        n_checks++;
        if (dut.wr_outstanding !== 5'd0 || wr_resp_err !== 1'b0) begin
            n_fail++; $display("FAIL single_bresp: got outstanding %0d err %b, required 0 and 0",
                dut.wr_outstanding, wr_resp_err);
        end
    endtask

    task automatic test_aw_stall();
        AXI_AWREADY = 1'b0; AXI_WREADY = 1'b1;
        push_write(34'h0_0000_005F, 256'hA5A5_0040, 1'b1);
        tick(1);
        n_checks++;
        if ({AXI_AWVALID, AXI_WVALID} !== 2'b11) begin
            n_fail++; $display("FAIL stall_issue: got valids %b, required 11", {AXI_AWVALID, AXI_WVALID});
        end
        tick(1);
        n_checks++;
        if ({AXI_AWVALID, AXI_WVALID} !== 2'b10 || AXI_AWADDR !== 34'h40) begin
            n_fail++; $display("FAIL stall_w_done: got valids %b addr %h, required 10 addr 40",
                {AXI_AWVALID, AXI_WVALID}, AXI_AWADDR);
        end
        for (int i = 0; i < 4; i++) begin
            tick(1);
            n_checks++;
            if (AXI_AWVALID !== 1'b1 || AXI_AWADDR !== 34'h40 || AXI_WVALID !== 1'b0) begin
                n_fail++; $display("FAIL stall_hold%0d: got aw %b w %b addr %h, required 1 0 40",
                    i, AXI_AWVALID, AXI_WVALID, AXI_AWADDR);
            end
        end
        AXI_AWREADY = 1'b1;
        tick(1);
        n_checks++;
        if (AXI_AWVALID !== 1'b0 || dut.wr_outstanding !== 5'd1) begin
            n_fail++; $display("FAIL stall_release: got awvalid %b outstanding %0d, required 0 and 1",
                AXI_AWVALID, dut.wr_outstanding);
        end
        send_b(1, 2'b00);
        tick(4);
        n_checks++;
        if (AXI_AWVALID !== 1'b0 || dut.wr_outstanding !== 5'd0) begin
            n_fail++; $display("FAIL stall_single_pop: got awvalid %b outstanding %0d, required 0 and 0",
                AXI_AWVALID, dut.wr_outstanding);
        end
    endtask

    task automatic test_back_to_back();
        int cycles;
        AXI_AWREADY = 1'b0; AXI_WREADY = 1'b0;
        for (int i = 0; i < 16; i++) begin
            push_write(34'(i * 32), {8{$urandom}}, 1'b1);
            if (i == 14) begin
                n_checks++;
                if (wr_full !== 1'b0) begin
                    n_fail++; $display("FAIL full_early: got wr_full %b after 15 pushes, required 0", wr_full);
                end
            end
        end
        n_checks++;
        if (wr_full !== 1'b1) begin
            n_fail++; $display("FAIL full_set: got wr_full %b after 16 pushes, required 1", wr_full);
        end
        push_write(34'h200, 256'hDEAD, 1'b0);
        n_checks++;
        if (wr_full !== 1'b1) begin
            n_fail++; $display("FAIL full_hold: got wr_full %b after dropped push, required 1", wr_full);
        end
        AXI_AWREADY = 1'b1; AXI_WREADY = 1'b1;
        wait_drain("b2b_drain", 200, cycles);
        n_checks++;
        if (cycles > 34) begin
            n_fail++; $display("FAIL b2b_rate: got %0d cycles for 16 writes, required <= 34", cycles);
        end
        tick(3);
        n_checks++;
        if (wr_full !== 1'b0 || dut.wr_outstanding !== 5'd16 || AXI_AWVALID !== 1'b0) begin
            n_fail++; $display("FAIL b2b_after: got full %b outstanding %0d awvalid %b, required 0 16 0",
                wr_full, dut.wr_outstanding, AXI_AWVALID);
        end
        send_b(16, 2'b00);
        n_checks++;
        if (dut.wr_outstanding !== 5'd0) begin
            n_fail++; $display("FAIL b2b_bresp: got outstanding %0d, required 0", dut.wr_outstanding);
        end
    endtask

    task automatic test_read();
        int cycles;
        AXI_AWREADY = 1'b1; AXI_WREADY = 1'b1; AXI_ARREADY = 1'b1;
        push_write(34'h0, '1, 1'b1);
        wait_drain("read_prewrite", 20, cycles);
        send_b(1, 2'b00);
        push_read(34'h0);
        tick(1);
        n_checks++;
        if (AXI_ARVALID !== 1'b1 || AXI_ARADDR !== 34'h0) begin
            n_fail++; $display("FAIL ar_issue: got arvalid %b addr %h, required 1 addr 0", AXI_ARVALID, AXI_ARADDR);
        end
        tick(1);
        n_checks++;
        if (AXI_ARVALID !== 1'b0 || dut.rd_outstanding !== 5'd1) begin
            n_fail++; $display("FAIL ar_accept: got arvalid %b outstanding %0d, required 0 and 1",
                AXI_ARVALID, dut.rd_outstanding);
        end
        tick(2);
        AXI_RVALID = 1'b1; AXI_RDATA = '1; AXI_RLAST = 1'b1; AXI_RRESP = 2'b00;
        exp_rd_q.push_back('1);
        tick(1);
        AXI_RVALID = 1'b0; AXI_RLAST = 1'b0; AXI_RDATA = '0;
        n_checks++;
        if (rd_data_valid !== 1'b1 || rd_data !== {256{1'b1}} || dut.rd_outstanding !== 5'd0) begin
            n_fail++; $display("FAIL rd_beat: got valid %b outstanding %0d data %h, required 1 0 all ones",
                rd_data_valid, dut.rd_outstanding, rd_data);
        end
        tick(1);
        n_checks++;
        if (rd_data_valid !== 1'b0 || rd_resp_err !== 1'b0) begin
            n_fail++; $display("FAIL rd_pulse: got valid %b err %b, required 0 and 0", rd_data_valid, rd_resp_err);
        end
    endtask

    task automatic test_resp_err_and_reset();
        int cycles;
        int seen;
        AXI_AWREADY = 1'b1; AXI_WREADY = 1'b1;
        push_write(34'h100, 256'h1234, 1'b1);
        wait_drain("err_write", 20, cycles);
        send_b(1, 2'b10);
        tick(3);
        n_checks++;
        if (wr_resp_err !== 1'b1) begin
            n_fail++; $display("FAIL wr_err_sticky: got %b, required 1", wr_resp_err);
        end
        for (int i = 0; i < 3; i++)
            push_write(34'h400 + 34'(i * 32), {8{$urandom}}, 1'b1);
        wait_drain("three_outstanding", 30, cycles);
        tick(1);
        n_checks++;
        if (dut.wr_outstanding !== 5'd3) begin
            n_fail++; $display("FAIL three_out: got %0d, required 3", dut.wr_outstanding);
        end
        AXI_AWREADY = 1'b0; AXI_WREADY = 1'b0; AXI_ARREADY = 1'b0;
        push_write(34'h800, 256'h77, 1'b1);
        push_read(34'h900);
        tick(1);
        n_checks++;
        if ({AXI_AWVALID, AXI_WVALID, AXI_ARVALID} !== 3'b111) begin
            n_fail++; $display("FAIL pre_reset_valids: got %b, required 111", {AXI_AWVALID, AXI_WVALID, AXI_ARVALID});
        end
        AXI_RVALID = 1'b1; AXI_RRESP = 2'b10; AXI_RLAST = 1'b0; AXI_RDATA = 256'hBAD;
        exp_rd_q.push_back(256'hBAD);
        tick(1);
        AXI_RVALID = 1'b0; AXI_RRESP = 2'b00; AXI_RDATA = '0;
        n_checks++;
        if (rd_resp_err !== 1'b1) begin
            n_fail++; $display("FAIL rd_err_set: got %b, required 1", rd_resp_err);
        end
        tick(1);
        AXI_ARESET = 1'b1;
        tick(1);
        exp_aw_q.delete(); exp_w_q.delete(); exp_ar_q.delete();
        n_checks++;
        if ({AXI_AWVALID, AXI_WVALID, AXI_ARVALID, rd_data_valid, wr_resp_err, rd_resp_err, wr_full, rd_full} !== 8'h00
            || rd_data !== '0) begin
            n_fail++; $display("FAIL mid_reset: got flags %b rd_data %h, required 00000000 and 0",
                {AXI_AWVALID, AXI_WVALID, AXI_ARVALID, rd_data_valid, wr_resp_err, rd_resp_err, wr_full, rd_full}, rd_data);
        end
        n_checks++;
        if (dut.wr_outstanding !== 5'd0 || dut.rd_outstanding !== 5'd0) begin
            n_fail++; $display("FAIL reset_counters: got wr %0d rd %0d, required 0 and 0",
                dut.wr_outstanding, dut.rd_outstanding);
        end
        AXI_ARESET = 1'b0;
        AXI_AWREADY = 1'b1; AXI_WREADY = 1'b1; AXI_ARREADY = 1'b1;
        send_b(1, 2'b00);
        AXI_RVALID = 1'b1; AXI_RLAST = 1'b1; AXI_RDATA = 256'h5;
        exp_rd_q.push_back(256'h5);
        tick(1);
        AXI_RVALID = 1'b0; AXI_RLAST = 1'b0; AXI_RDATA = '0;
        n_checks++;
        if (dut.wr_outstanding !== 5'd0 || dut.rd_outstanding !== 5'd0) begin
            n_fail++; $display("FAIL late_resp_saturate: got wr %0d rd %0d, required 0 and 0",
                dut.wr_outstanding, dut.rd_outstanding);
        end
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (AXI_AWVALID || AXI_WVALID || AXI_ARVALID) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++; $display("FAIL fifo_flushed: got %0d cycles with VALID after reset, required 0", seen);
        end
    endtask

    initial begin
        AXI_ARESET = 1'b1;
        write_enable = 1'b0; write_address = '0; write_data = '0;
        read_enable = 1'b0; read_address = '0;
        AXI_AWREADY = 1'b0; AXI_WREADY = 1'b0; AXI_ARREADY = 1'b0;
        AXI_BVALID = 1'b0; AXI_BRESP = 2'b00;
        AXI_RVALID = 1'b0; AXI_RLAST = 1'b0; AXI_RRESP = 2'b00; AXI_RDATA = '0;
        test_reset();
        test_single_write();
        test_aw_stall();
        test_back_to_back();
        test_read();
        test_resp_err_and_reset();
        n_checks++;
        if (exp_rd_q.size() != 0) begin
            n_fail++; $display("FAIL rd_leftover: got %0d undelivered beats, required 0", exp_rd_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout at %0t, required completion", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hbm_axi_port_master.md
HBM_AXI_PORT_MASTER -- requirements
Module: hbm_axi_port_master

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, sets write- and read-command FIFO depth (power of two, >=2).
REQ-002 Parameter MAX_OUTSTANDING, default 16, sets the maximum number of unacknowledged AW or AR transactions.
REQ-003 AXI_ACLK  input  1  the single clock for all logic.
REQ-004 AXI_ARESET  input  1  reset; synchronous and active-high.
REQ-005 write_enable  input  1  one write request per cycle when high.
REQ-006 write_address  input  34  byte address of the write; bits [4:0] ignored.
REQ-007 write_data  input  256  write payload.
REQ-008 read_enable  input  1  one read request per cycle when high.
REQ-009 read_address  input  34  byte address of the read; bits [4:0] ignored.
REQ-010 wr_full / rd_full  output  1 each  the corresponding command FIFO is full.
REQ-011 rd_data_valid / rd_data  output  1 / 256  returned read beat; pulse is one cycle per beat.
REQ-012 wr_resp_err / rd_resp_err  output  1 each  sticky flags; set on non-OKAY BRESP or RRESP.
REQ-013 AXI_AW*: AWADDR 34, AWVALID, AWREADY(in), AWLEN 4, AWSIZE 3, AWBURST 2, AWID 6.
REQ-014 AXI_W*: WDATA 256, WSTRB 32, WLAST, WVALID, WREADY(in).
REQ-015 AXI_B*: BVALID(in), BRESP(in) 2, BREADY.
REQ-016 AXI_AR*: ARADDR 34, ARVALID, ARREADY(in), ARLEN 4, ARSIZE 3, ARBURST 2, ARID 6.
REQ-017 AXI_R*: RDATA(in) 256, RVALID(in), RLAST(in), RRESP(in) 2, RREADY.

Function
REQ-018 Every transaction is a single 32-byte beat with LEN=0, SIZE=3'b101, BURST=INCR, ID=0, WSTRB all ones and WLAST=1.
REQ-019 A write request is accepted when write_enable=1 and wr_full=0. The FIFO stores {address[33:5],5'b0, data}. A request made while full is dropped silently.
REQ-020 The write path uses three states:
- IDLE to SEND when the FIFO is not empty and outstanding < MAX_OUTSTANDING. The head entry is registered at this transition.
- SEND drives AWVALID and WVALID together. Each is deasserted independently once its READY is seen.
- SEND to IDLE once both handshakes are complete, in the same or different cycles. The FIFO pops on that cycle.
REQ-021 AWVALID and WVALID, once asserted, hold stable with their payload until accepted.
REQ-022 The write outstanding counter behaves as follows:
- It increments on the AW handshake and decrements on B handshake.
- A simultaneous increment and decrement leaves it unchanged.
- BREADY is always 1.
REQ-023 The read path mirrors the write path:
- States are IDLE and SEND_AR.
- ARVALID is held until ARREADY.
- The read outstanding counter increments on AR handshake and decrements on R handshake with RLAST=1.
REQ-024 RREADY is always 1. rd_data_valid equals RVALID registered one cycle, and rd_data equals RDATA registered in the same cycle.
REQ-025 Minimum latency is 1 cycle from request accepted to xVALID high, with an empty FIFO and READY high. Sustained throughput is one write every 2 cycles.
REQ-026 wr_full and rd_full are registered and assert when the count equals FIFO_DEPTH. A push and pop in the same cycle while full is not permitted, because push is blocked.
REQ-027 FIFO pointers wrap modulo FIFO_DEPTH. The count is log2(FIFO_DEPTH)+1 bits wide.
REQ-028 Write and read paths are fully independent. No ordering is enforced between them.

Reset
REQ-029 While AXI_ARESET=1, the following are cleared on the next AXI_ACLK edge:
- all VALID outputs;
- both FIFOs, to empty;
- both counters;
- both FSMs, to IDLE;
- rd_data_valid, rd_data, both error flags and both full flags.
REQ-030 Reset asserted mid-transaction abandons it. Late B or R responses arriving after reset do not underflow the counters, which saturate at 0.

Structure
REQ-031 A shared package hbm_axi_pkg holds the following constants:
- ADDR_W=34, DATA_W=256, ID_W=6;
- AXI_SIZE_32B, BURST_INCR, RESP_OKAY;
- the write-command struct.
REQ-032 One sub-module, hbm_cmd_fifo, is a synchronous parameterised FIFO instantiated twice (write and read).

Verification
REQ-033 Single write to 0x0_0000_0020 with data 0x4920, AWREADY=WREADY=1 -> AWVALID and WVALID high 1 cycle after the request with AWADDR=0x20. Then BVALID drops the counter to 0.
REQ-034 AWREADY held low 5 cycles, WREADY=1 -> WVALID drops after 1 cycle, AWVALID is held with a stable address until the 6th cycle, and only one FIFO pop occurs.
REQ-035 16 back-to-back writes, 0x0 to 0x1E0 step 0x20, with AWREADY=0 -> wr_full asserts after the 16th push, the 17th request is dropped, and all 16 are issued in order once ready.
REQ-036 A read of 0x0 after writing all-ones, with RVALID, RDATA=all ones and RLAST=1 returned 3 cycles after AR -> rd_data_valid pulses 1 cycle with rd_data all ones, and the read counter returns to 0.
REQ-037 BRESP=2'b10 on one write -> wr_resp_err sets and stays set until AXI_ARESET. AXI_ARESET asserted with 3 outstanding -> all outputs cleared next edge, and a subsequent BVALID leaves the counter at 0.
